// File: rtl/pipe_stage_reg.sv
// Flushable pipeline-stage register with valid/ready handshake and a 2-entry skid buffer.
// Optional statistics counters (stall_cnt, flush_cnt) are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_reg #(
   parameter int WIDTH       = 32,
   parameter int CLR_PAYLOAD = 1,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
`ifdef PIPE_STAGE_STATS_EN
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
`endif
   input  logic             out_ready
);

   logic             main_v_q, main_v_d;
   logic             skid_v_q, skid_v_d;
   logic             in_rdy_q, in_rdy_d;
   logic [WIDTH-1:0] main_dat_q, main_dat_d;
   logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
   logic             in_fire, out_fire;

   assign in_fire   = in_valid & in_rdy_q;
   assign out_fire  = main_v_q & out_ready;
   assign in_ready  = in_rdy_q;
   assign out_valid = main_v_q;
   assign out_data  = main_dat_q;

   always_comb begin
      main_v_d   = main_v_q;
      skid_v_d   = skid_v_q;
      main_dat_d = main_dat_q;
      skid_dat_d = skid_dat_q;
      if (flush) begin
         // An out_fire in this cycle has already been taken downstream; only held state is dropped.
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
         if (CLR_PAYLOAD != 0) begin
            main_dat_d = '0;
            skid_dat_d = '0;
         end
      end else if (!main_v_q) begin
         if (in_fire) begin
            main_v_d   = 1'b1;
            main_dat_d = in_data;
         end
      end else if (!skid_v_q) begin
         if (in_fire && out_fire) begin
            main_dat_d = in_data;
         end else if (in_fire) begin
            skid_v_d   = 1'b1;
            skid_dat_d = in_data;
         end else if (out_fire) begin
            main_v_d = 1'b0;
         end
      end else if (out_fire) begin
         main_dat_d = skid_dat_q;
         skid_v_d   = 1'b0;
      end
      // Registered so out_ready never reaches in_ready combinationally.
      in_rdy_d = ~skid_v_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         in_rdy_q <= 1'b1;
      end else begin
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
         in_rdy_q <= in_rdy_d;
      end
   end

   generate
      if (CLR_PAYLOAD != 0) begin : g_pay_rst
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               main_dat_q <= '0;
               skid_dat_q <= '0;
            end else begin
               main_dat_q <= main_dat_d;
               skid_dat_q <= skid_dat_d;
            end
         end
      end else begin : g_pay_norst
         always_ff @(posedge clk) begin
            main_dat_q <= main_dat_d;
            skid_dat_q <= skid_dat_d;
         end
      end
   endgenerate

`ifdef PIPE_STAGE_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (main_v_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != {CNT_W{1'b1}}))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: stimulus pushes expected beats into a queue,
// a negedge monitor pops and compares every beat the DUT hands downstream.
module tb_pipe_stage_reg;
   localparam int WIDTH = 32;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready = 1'b0;
`ifdef PIPE_STAGE_STATS_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
`endif

   int total = 0;
   int bad   = 0;
   logic [WIDTH-1:0] exp_q[$];

   pipe_stage_reg #(.WIDTH(WIDTH), .CLR_PAYLOAD(1), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data),
`ifdef PIPE_STAGE_STATS_EN
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every downstream handshake must match the next expected beat.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got 0x%0h expected none", out_data);
         end else begin
            check("out_beat", 64'(out_data), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      // Reset with a beat already offered.
      in_valid = 1'b1;
      in_data  = 32'hDEADBEEF;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_data", 64'(out_data), 64'd0);
      exp_q.push_back(32'hDEADBEEF);
      rst_n = 1'b1;
      step();
      check("first_latency_valid", 64'(out_valid), 64'd1);
      check("first_latency_data", 64'(out_data), 64'hDEADBEEF);
      in_valid = 1'b0;
      step();

      // Streaming 1..8 back-to-back.
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1;
         in_data  = WIDTH'(i);
         exp_q.push_back(WIDTH'(i));
         check("stream_in_ready", 64'(in_ready), 64'd1);
         step();
         check("stream_no_gap", 64'(out_valid), 64'd1);
      end
      in_valid = 1'b0;
      step();
      check("stream_drained", 64'(out_valid), 64'd0);

      // Backpressure into TWO, then release.
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'hA; exp_q.push_back(32'hA);
      check("bp_rdy_a", 64'(in_ready), 64'd1);
      step();
      in_data = 32'hB; exp_q.push_back(32'hB);
      check("bp_rdy_b", 64'(in_ready), 64'd1);
      step();
      in_data = 32'hC; exp_q.push_back(32'hC);
      check("bp_rdy_two", 64'(in_ready), 64'd0);
      check("bp_hold_a", 64'(out_data), 64'hA);
      step();
      check("bp_rdy_two_hold", 64'(in_ready), 64'd0);
      check("bp_hold_a2", 64'(out_data), 64'hA);
      out_ready = 1'b1;
      step();
      check("bp_rdy_back", 64'(in_ready), 64'd1);
      check("bp_main_b", 64'(out_data), 64'hB);
      step();
      in_valid = 1'b0;
      check("bp_main_c", 64'(out_data), 64'hC);
      step();
      check("bp_drained", 64'(out_valid), 64'd0);

      // Long stall: payload held, stall counter saturates.
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h42; exp_q.push_back(32'h42);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         check("stall_hold", 64'(out_data), 64'h42);
         step();
      end
`ifdef PIPE_STAGE_STATS_EN
      check("stall_cnt_sat", 64'(stall_cnt), 64'd15);
`endif
      out_ready = 1'b1;
      step();
      check("stall_drained", 64'(out_valid), 64'd0);

      // Flush #1 in TWO with a beat offered (in_ready=0).
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'hD1;
      step();
      in_data = 32'hD2;
      step();
      check("pre_flush_two", 64'(in_ready), 64'd0);
      in_data = 32'hF0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush_two_valid", 64'(out_valid), 64'd0);
      check("flush_two_ready", 64'(in_ready), 64'd1);
      check("flush_two_data", 64'(out_data), 64'd0);

      // Flush #2 in EMPTY with an accepted-looking beat: it must be discarded.
      in_valid = 1'b1; in_data = 32'h77;
      flush = 1'b1;
      check("flush_empty_rdy", 64'(in_ready), 64'd1);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush_drop_valid", 64'(out_valid), 64'd0);
      step();
      check("flush_drop_valid2", 64'(out_valid), 64'd0);

      // Flush #3 in ONE while downstream takes the beat: it still counts as delivered.
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 32'h55;
      step();
      in_valid = 1'b0;
      exp_q.push_back(32'h55);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_one_valid", 64'(out_valid), 64'd0);
`ifdef PIPE_STAGE_STATS_EN
      check("flush_cnt", 64'(flush_cnt), 64'd3);
`endif

      // Asynchronous reset while in TWO.
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h61;
      step();
      in_data = 32'h62;
      step();
      in_valid = 1'b0;
      check("pre_arst_two", 64'(in_ready), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(out_valid), 64'd0);
      check("arst_ready", 64'(in_ready), 64'd1);
      check("arst_data", 64'(out_data), 64'd0);
`ifdef PIPE_STAGE_STATS_EN
      check("arst_stall_cnt", 64'(stall_cnt), 64'd0);
      check("arst_flush_cnt", 64'(flush_cnt), 64'd0);
`endif
      step();
      rst_n = 1'b1;
      step();

      // Recovery beat.
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 32'h99; exp_q.push_back(32'h99);
      step();
      in_valid = 1'b0;
      check("recover_data", 64'(out_data), 64'h99);
      repeat (3) step();
      check("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
